p4_router_ingress_sched: RTL

// - Packet-granular weighted round-robin scheduler: shares the single VNP4 ingress stream among the
//   NUM_ING_AXIS_ARRAYS width-group streams (8b/16b/32b/64b port arrays, each already width-converted to DATA_W).
// - Sits between the per-array ingress width converters and the VNP4 pipeline input.
// - Grants are held for a whole packet (until tlast); per-requester weight = packets per round.

---
 rtl/p4_router_ingress_sched_pkg.sv | 20 ++
 rtl/p4_router_ingress_sched_if.sv | 19 +
 rtl/p4_router_ingress_sched_rr_pick.sv | 33 +++
 rtl/p4_router_ingress_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/p4_router_ingress_sched_pkg.sv
// Shared types and constants for the VNP4 ingress scheduler.
//   NUM_ING_AXIS_ARRAYS : number of width-group ingress streams (8b/16b/32b/64b arrays)
//   ING_SCHED_WEIGHT_W  : width of a scheduler weight / credit counter
//   ing_sched_state_t   : scheduler FSM state
//   rr_wrap_inc         : index + 1, wrapping at n
package p4_router_ingress_sched_pkg;

  localparam int NUM_ING_AXIS_ARRAYS = 4;
  localparam int ING_SCHED_WEIGHT_W  = 4;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_XFER = 1'b1
  } ing_sched_state_t;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/p4_router_ingress_sched_if.sv
// AXI-Stream bundle carrying N parallel streams (N=1 for a single stream).
//   tvalid/tready/tlast : per-stream handshake and end of packet
//   tdata/tkeep/tuser   : per-stream payload, byte enables, sideband
// master drives payload and valid, slave drives ready.
interface p4_router_ingress_sched_if #(
  parameter int N      = 1,
  parameter int DATA_W = 512,
  parameter int USER_W = 16
) ();
  logic [N-1:0]                tvalid;
  logic [N-1:0]                tready;
  logic [N-1:0]                tlast;
  logic [N-1:0][DATA_W-1:0]    tdata;
  logic [N-1:0][DATA_W/8-1:0]  tkeep;
  logic [N-1:0][USER_W-1:0]    tuser;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/p4_router_ingress_sched_rr_pick.sv
// Combinational rotating-priority encoder.
//   req_i : request vector
//   ptr_i : index holding highest priority this cycle
//   gnt_o : one-hot grant, first request at or after ptr_i (wrapping)
//   idx_o : index of the granted request
//   vld_o : at least one request present
module p4_router_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);
  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/p4_router_ingress_sched.sv
// Packet-granular weighted round-robin scheduler feeding the VNP4 ingress.
//   clk, areset_n : clock, async active-low reset
//   s_axis        : NUM_REQ ingress streams (slave)
//   m_axis        : single stream towards VNP4 (master)
//   cfg_enable    : per-requester enable
//   cfg_weight    : packets per round, 0 acts as 1, sampled on credit reload
//   sts_grant     : one-hot current grant, 0 while idle
//   sts_pkt_cnt   : packets forwarded per requester, wrapping
// Grants are held until tlast; one idle cycle separates packets so the
// arbitration decision never depends combinationally on m_tready.
module p4_router_ingress_sched
  import p4_router_ingress_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_ING_AXIS_ARRAYS,
  parameter int DATA_W   = 512,
  parameter int USER_W   = 16,
  parameter int WEIGHT_W = ING_SCHED_WEIGHT_W
) (
  input  logic                              clk,
  input  logic                              areset_n,
  p4_router_ingress_sched_if.slave          s_axis,
  p4_router_ingress_sched_if.master         m_axis,
  input  logic [NUM_REQ-1:0]                cfg_enable,
  input  logic [NUM_REQ-1:0][WEIGHT_W-1:0]  cfg_weight,
  output logic [NUM_REQ-1:0]                sts_grant,
  output logic [NUM_REQ-1:0][31:0]          sts_pkt_cnt
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ing_sched_state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]               grant_q;
  logic [IDX_W-1:0]                 gidx_q;
  logic [IDX_W-1:0]                 rr_ptr_q;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0] credit_q, credit_d;
  logic [NUM_REQ-1:0][31:0]         pkt_cnt_q, pkt_cnt_d;

  logic [NUM_REQ-1:0] en_vld, credit_nz, elig, pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld, reload, win, done;
  logic [DATA_W-1:0]  mux_data;
  logic [USER_W-1:0]  mux_user;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign credit_nz[i] = |credit_q[i];
  end

  assign en_vld = s_axis.tvalid & cfg_enable;
  assign elig   = en_vld & credit_nz;
  // Everyone who wants to send has spent its credit: start a new round.
  assign reload = (state_q == SCHED_IDLE) && (elig == '0) && (en_vld != '0);
  assign win    = (state_q == SCHED_IDLE) && pick_vld;
  assign done   = (state_q == SCHED_XFER) && m_axis.tvalid[0] && m_axis.tready[0]
                  && s_axis.tlast[gidx_q];

  p4_router_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= SCHED_IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE: if (win)  state_d = SCHED_XFER;
      SCHED_XFER: if (done) state_d = SCHED_IDLE;
      default:              state_d = SCHED_IDLE;
    endcase
  end

  // FSM: outputs; the stream path is only opened while a grant is held
  assign mux_data = s_axis.tdata[gidx_q];
  assign mux_user = s_axis.tuser[gidx_q];

  always_comb begin
    m_axis.tvalid = 1'b0;
    s_axis.tready = '0;
    m_axis.tdata  = mux_data;
    m_axis.tkeep  = s_axis.tkeep[gidx_q];
    m_axis.tuser  = mux_user;
    m_axis.tlast  = s_axis.tlast[gidx_q];
    if (state_q == SCHED_XFER) begin
      m_axis.tvalid = s_axis.tvalid[gidx_q];
      s_axis.tready = grant_q & {NUM_REQ{m_axis.tready[0]}};
    end
  end

  // Grant and rotating pointer. The pointer only moves past a requester once
  // its credit for this round is exhausted, so weight = back-to-back packets.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else if (win) begin
      grant_q <= pick_gnt;
      gidx_q  <= pick_idx;
    end else if (done) begin
      grant_q <= '0;
      if (credit_q[gidx_q] == WEIGHT_W'(1))
        rr_ptr_q <= IDX_W'(rr_wrap_inc(int'(gidx_q), NUM_REQ));
    end
  end

  always_comb begin
    credit_d  = credit_q;
    pkt_cnt_d = pkt_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reload)
        credit_d[i] = (cfg_weight[i] == '0) ? WEIGHT_W'(1) : cfg_weight[i];
      else if (done && (gidx_q == IDX_W'(i))) begin
        credit_d[i]  = credit_q[i] - WEIGHT_W'(1);
        pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      credit_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      credit_q  <= credit_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign sts_grant   = grant_q;
  assign sts_pkt_cnt = pkt_cnt_q;
endmodule
